// File: rtl/cpu_if_reg_target_if.sv
// Single-cycle request / completion bus between the CPU bridge (master)
// and a register-bank responder (slave).
interface cpu_if_reg_target_if;
  logic        read;
  logic        write;
  logic [29:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        access_complete;

  modport master (
    output read, write, address, write_data,
    input  read_data, access_complete
  );

  modport slave (
    input  read, write, address, write_data,
    output read_data, access_complete
  );
endinterface

// File: rtl/cpu_if_reg_target.sv
// Register-bank responder for cpu_if: ID, status, overrun count, cycle count
// and scratch words in a 16-word window, with a programmable response delay.
module cpu_if_reg_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter int          NUM_SCRATCH = 8,
  parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input logic          clk,
  input logic          reset,
  cpu_if_reg_target_if.slave bus
);

  localparam int         DATA_W    = 32;
  localparam int         SCR_W     = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [7:0] WAIT_INIT = 8'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                    state;
  logic [7:0]                wait_cnt;
  logic [3:0]                off_q;
  logic                      rd_q, wr_q, err_q;
  logic        [DATA_W-1:0]  wdata_q;
  logic        [DATA_W-1:0]  scratch [NUM_SCRATCH];
  logic [1:0]                status;
  logic [15:0]               ovr_cnt;
  logic        [DATA_W-1:0]  cyc_cnt;
  logic        [DATA_W-1:0]  read_data_r;
  logic                      ack_r;

  logic                      req, in_hit, in_err;
  logic [3:0]                a_off;
  logic                      a_rd, a_wr, a_err;
  logic        [DATA_W-1:0]  a_wdata;
  logic                      go_resp, ovr_evt, wr_ok;
  logic [1:0]                status_clr;
  logic        [DATA_W-1:0]  rd_val;
  logic [SCR_W-1:0]          scr_idx;

  function automatic logic decode_err(input logic hit, input logic [3:0] off,
                                      input logic rd, input logic wr);
    int o;
    o = int'(off);
    return !hit || (o > 3 + NUM_SCRATCH) ||
           (wr && (o == 0 || o == 2 || o == 3)) || (rd && wr);
  endfunction

  assign req    = bus.read | bus.write;
  assign in_hit = (bus.address[29:4] == BASE_ADDR[31:6]);
  assign in_err = decode_err(in_hit, bus.address[3:0], bus.read, bus.write);

  // The access happens on the edge entering RESP; with no wait states that is
  // the accept edge itself, so the live request is used instead of the latch.
  always_comb begin
    if (state == S_IDLE) begin
      a_off   = bus.address[3:0];
      a_rd    = bus.read;
      a_wr    = bus.write;
      a_err   = in_err;
      a_wdata = bus.write_data;
    end else begin
      a_off   = off_q;
      a_rd    = rd_q;
      a_wr    = wr_q;
      a_err   = err_q;
      a_wdata = wdata_q;
    end
  end

  assign go_resp    = ((state == S_IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && (wait_cnt == 8'd0));
  assign ovr_evt    = req && (state != S_IDLE);
  assign wr_ok      = go_resp && a_wr && !a_err;
  assign status_clr = (wr_ok && (a_off == 4'd1)) ? a_wdata[1:0] : 2'b00;
  assign scr_idx    = SCR_W'(a_off - 4'd4);

  always_comb begin
    rd_val = ERR_DATA;
    case (a_off)
      4'd0: rd_val = ID_VALUE;
      4'd1: rd_val = {30'd0, status};
      4'd2: rd_val = {16'd0, ovr_cnt};
      4'd3: rd_val = cyc_cnt;
      default: if (int'(a_off) < 4 + NUM_SCRATCH) rd_val = scratch[scr_idx];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      off_q       <= 4'd0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      status      <= 2'b00;
      ovr_cnt     <= 16'd0;
      read_data_r <= '0;
      ack_r       <= 1'b0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      ack_r <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          off_q   <= bus.address[3:0];
          rd_q    <= bus.read;
          wr_q    <= bus.write;
          err_q   <= in_err;
          wdata_q <= bus.write_data;
          if (WAIT_CYCLES == 0) begin
            state <= S_RESP;
            ack_r <= 1'b1;
          end else begin
            state    <= S_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        S_WAIT: if (wait_cnt == 8'd0) begin
          state <= S_RESP;
          ack_r <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt - 8'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (go_resp && a_rd) read_data_r <= a_err ? ERR_DATA : rd_val;
      if (wr_ok && (a_off >= 4'd4)) scratch[scr_idx] <= a_wdata;
      // Set events take priority over a simultaneous write-1-to-clear.
      status <= (status & ~status_clr) | {ovr_evt, go_resp && a_err};
      if (ovr_evt && (ovr_cnt != 16'hFFFF)) ovr_cnt <= ovr_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_cnt <= '0;
    else       cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign bus.read_data       = read_data_r;
  assign bus.access_complete = ack_r;

endmodule

// File: tb/tb_cpu_if_reg_target.sv
// Directed bench for cpu_if_reg_target: a 2-wait-state instance for the
// register map and a 255-wait-state instance for overrun-count saturation.
module tb_cpu_if_reg_target;

  localparam logic [29:0] B1 = 30'h2000_0040;  // word base of 32'h8000_0100

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  cpu_if_reg_target_if bus1 ();
  cpu_if_reg_target_if bus2 ();

  cpu_if_reg_target #(.BASE_ADDR(32'h8000_0100), .WAIT_CYCLES(2), .NUM_SCRATCH(8)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  cpu_if_reg_target #(.BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(255), .NUM_SCRATCH(1)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access1(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus1.read = rd; bus1.write = wr; bus1.address = addr; bus1.write_data = wd;
    @(posedge clk); #1;
    bus1.read = 1'b0; bus1.write = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (bus1.access_complete) begin lat = k; break; end
      @(posedge clk); #1;
    end
    rdata = bus1.read_data;
  endtask

  task automatic access2(input logic [29:0] addr, output logic [31:0] rdata, output int lat);
    @(posedge clk); #1;
    bus2.read = 1'b1; bus2.address = addr;
    @(posedge clk); #1;
    bus2.read = 1'b0;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      if (bus2.access_complete) begin lat = k; break; end
      @(posedge clk); #1;
    end
    rdata = bus2.read_data;
  endtask

  task automatic rd1(input logic [3:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    int          lat;
    access1(1'b1, 1'b0, B1 | 30'(off), 32'd0, d, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check(tag, d, exp);
  endtask

  task automatic wr1(input logic [3:0] off, input logic [31:0] data, input string tag);
    logic [31:0] d;
    int          lat;
    access1(1'b0, 1'b1, B1 | 30'(off), data, d, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
  endtask

  initial begin
    logic [31:0] d, v1, v2;
    int          lat, acks;

    bus1.read = 1'b0; bus1.write = 1'b0; bus1.address = '0; bus1.write_data = '0;
    bus2.read = 1'b0; bus2.write = 1'b0; bus2.address = '0; bus2.write_data = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ack", {31'd0, bus1.access_complete}, 32'd0);
    check("rst_rdata", bus1.read_data, 32'd0);
    check("rst_ack2", {31'd0, bus2.access_complete}, 32'd0);

    // ID read with latency and single-cycle completion
    access1(1'b1, 1'b0, B1, 32'd0, d, lat);
    check("id_lat", 32'(lat), 32'd3);
    check("id_data", d, 32'hC0DE_0001);
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, bus1.access_complete}, 32'd0);

    // Scratch write/read; writes leave read_data untouched
    access1(1'b0, 1'b1, B1 | 30'd4, 32'h1234_5678, d, lat);
    check("wr_lat", 32'(lat), 32'd3);
    check("wr_keeps_rdata", d, 32'hC0DE_0001);
    rd1(4'd4, 32'h1234_5678, "scr0");
    rd1(4'd5, 32'h0000_0000, "scr1_reset");

    // Out-of-range read, sticky error and its clear
    rd1(4'd12, 32'hDEAD_BEEF, "oor_read");
    rd1(4'd1, 32'h0000_0001, "status_err");
    wr1(4'd1, 32'h0000_0001, "status_clr");
    rd1(4'd1, 32'h0000_0000, "status_after_clr");

    // Errored write to a read-only offset
    rd1(4'd0, 32'hC0DE_0001, "id_again");
    access1(1'b0, 1'b1, B1, 32'h0000_FFFF, d, lat);
    check("ro_wr_keeps_rdata", d, 32'hC0DE_0001);
    rd1(4'd0, 32'hC0DE_0001, "id_unchanged");
    rd1(4'd1, 32'h0000_0001, "status_ro_err");
    wr1(4'd1, 32'h0000_0003, "status_clr2");

    // Window miss
    access1(1'b1, 1'b0, 30'h0000_0005, 32'd0, d, lat);
    check("miss_lat", 32'(lat), 32'd3);
    check("miss_data", d, 32'hDEAD_BEEF);
    wr1(4'd1, 32'h0000_0003, "status_clr3");
    rd1(4'd1, 32'h0000_0000, "status_clean");

    // Overrun: second request one cycle after the first is dropped
    @(posedge clk); #1;
    bus1.read = 1'b1; bus1.address = B1;
    @(posedge clk); #1;
    bus1.address = B1 | 30'd4;
    @(posedge clk); #1;
    bus1.read = 1'b0;
    acks = 0;
    repeat (10) begin
      if (bus1.access_complete) acks++;
      @(posedge clk); #1;
    end
    check("ovr_single_ack", 32'(acks), 32'd1);
    check("ovr_inflight_data", bus1.read_data, 32'hC0DE_0001);
    rd1(4'd1, 32'h0000_0002, "status_ovr");
    rd1(4'd2, 32'h0000_0001, "ovr_count1");

    // Read and write together
    access1(1'b1, 1'b1, B1 | 30'd4, 32'hAAAA_5555, d, lat);
    check("both_lat", 32'(lat), 32'd3);
    check("both_data", d, 32'hDEAD_BEEF);
    rd1(4'd4, 32'h1234_5678, "both_scr_unchanged");
    rd1(4'd1, 32'h0000_0003, "both_status");
    wr1(4'd1, 32'h0000_0003, "status_clr4");
    rd1(4'd1, 32'h0000_0000, "status_clean2");

    // Overrun set on the same edge as a STATUS clear: set wins
    @(posedge clk); #1;
    bus1.write = 1'b1; bus1.address = B1 | 30'd1; bus1.write_data = 32'h0000_0002;
    @(posedge clk); #1;
    bus1.write = 1'b0;
    @(posedge clk); #1;
    bus1.read = 1'b1; bus1.address = B1;
    @(posedge clk); #1;
    bus1.read = 1'b0;
    acks = 0;
    repeat (6) begin
      if (bus1.access_complete) acks++;
      @(posedge clk); #1;
    end
    check("setwin_ack", 32'(acks), 32'd1);
    rd1(4'd1, 32'h0000_0002, "setwin_status");
    rd1(4'd2, 32'h0000_0002, "ovr_count2");

    // Reset during WAIT
    @(posedge clk); #1;
    bus1.read = 1'b1; bus1.address = B1;
    @(posedge clk); #1;
    bus1.read = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    acks = 0;
    repeat (8) begin
      if (bus1.access_complete) acks++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_ack", 32'(acks), 32'd0);
    check("rst_mid_rdata", bus1.read_data, 32'd0);
    rd1(4'd1, 32'h0000_0000, "rst_mid_status");
    rd1(4'd2, 32'h0000_0000, "rst_mid_ovr");

    // Cycle counter: small after reset, advances by request spacing
    access1(1'b1, 1'b0, B1 | 30'd3, 32'd0, v1, lat);
    check("cyc_small", {31'd0, (v1 < 32'd64)}, 32'd1);
    repeat (6) @(posedge clk);
    access1(1'b1, 1'b0, B1 | 30'd3, 32'd0, v2, lat);
    check("cyc_delta", v2 - v1, 32'd10);

    // Overrun count saturation on the long-wait instance
    @(posedge clk); #1;
    bus2.read = 1'b1; bus2.address = 30'd0;
    repeat (66000) @(posedge clk);
    #1 bus2.read = 1'b0;
    repeat (300) @(posedge clk);
    access2(30'd2, d, lat);
    check("sat_lat", 32'(lat), 32'd256);
    check("sat_count", d, 32'h0000_FFFF);
    access2(30'd5, d, lat);
    check("dut2_oor", d, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_if_reg_target.md
Name: cpu_if_reg_target

Overview:
- Register-bank responder for the Master end of cpu_if: accepts the single-cycle read/write pulses driven by the CPU bridge, decodes the word address, performs the access and returns access_complete with read_data.
- Sits in the high-speed clock domain as the leaf peripheral behind the clock-domain bridge.
- Provides ID, status, overrun, cycle-count and scratch registers for bring-up and for bridge verification.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte base address of the 16-word window; bits [5:0] must be 0.
- WAIT_CYCLES, 2, cycles from request accept to access_complete, 0..255.
- NUM_SCRATCH, 8, number of RW scratch words at offsets 4.., range 1..12.
- ID_VALUE, 32'hC0DE_0001, constant returned at offset 0.
- ERR_DATA, 32'hDEAD_BEEF, read_data value for an errored read.

Ports:
- clk  in  1  block clock (cpu_if clk)
- reset  in  1  synchronous, active-high
- read  in  1  read request pulse
- write  in  1  write request pulse
- address  in  30  word address [31:2]; valid in the request cycle
- write_data  in  32  valid in the write request cycle
- read_data  out  32  response data
- access_complete  out  1  one-cycle completion pulse

Behaviour:
- Reset and clocking:
  - One clock (clk); reset is synchronous and active-high.
  - Reset values: access_complete=0, read_data=0, scratch=0, STATUS=0, OVERRUN_COUNT=0, CYCLE_COUNT=0, FSM=IDLE.
- Decode:
  - hit = address[31:6]==BASE_ADDR[31:6]; off = address[5:2].
  - Valid offsets: 0..3+NUM_SCRATCH.
  - Error = miss, off out of range, write to RO offset (0, 2, 3), or read and write both high in the same cycle.
- Register map:
  - 0 ID: RO, ID_VALUE.
  - 1 STATUS: bit0 err_sticky, bit1 overrun_sticky; write-1-to-clear; other bits read 0.
  - 2 OVERRUN_COUNT: RO, [15:0] saturating at 16'hFFFF, upper bits 0.
  - 3 CYCLE_COUNT: RO, 32-bit, +1 every non-reset cycle, wraps FFFF_FFFF→0.
  - 4+i SCRATCH[i]: RW.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when read|write=1, latch address, write_data, op and error flag, then go to WAIT. With WAIT_CYCLES=0, go straight to RESP.
  - WAIT: down-counter loaded with WAIT_CYCLES-1; go to RESP when it reaches 0.
  - RESP: drive access_complete=1 for exactly this cycle, then return to IDLE.
  - Latency: access_complete rises WAIT_CYCLES+1 cycles after the request cycle.
- Side effects, all applied in the RESP cycle:
  - Write: register update on non-error.
  - Read: read_data <= register value, or ERR_DATA on error.
  - Error: err_sticky set.
  - A write to STATUS clears the addressed bits. If a new set event occurs in the same cycle as a clear, set wins.
- read_data holding: stable from RESP until the next read's RESP. Writes and errored writes leave read_data unchanged.
- Overrun: read|write asserted while not in IDLE (including the RESP cycle):
  - the request is dropped;
  - overrun_sticky is set;
  - OVERRUN_COUNT increments, saturating;
  - the in-flight access is unaffected.
- Both read and write high: no register change; read_data <= ERR_DATA; err_sticky set; completion is still given.
- Reset mid-access: FSM returns to IDLE, no access_complete is issued, and no side effect of the pending access occurs.

Test Plan:
- Reset, then read offset 0 with WAIT_CYCLES=2 → access_complete high exactly 3 cycles after the request for 1 cycle; read_data=C0DE_0001.
- Write 32'h1234_5678 to off 4, then read off 4 → read_data=1234_5678. Read off 5 → 0.
- Read off 12 (NUM_SCRATCH=8) → read_data=DEAD_BEEF, STATUS=1. Write 1 to STATUS bit0 → STATUS read returns 0.
- Issue a second read 1 cycle after the first → single access_complete; STATUS bit1=1; OVERRUN_COUNT=1. Repeat 65540 times → count=FFFF.
- Read and write asserted together to off 4 → access_complete given; SCRATCH[0] unchanged; read_data=DEAD_BEEF; err_sticky=1.
- Assert reset during WAIT → no access_complete. Next read of CYCLE_COUNT returns a small value; two reads 10 cycles apart differ by 10.
